// File: rtl/ibex_pkg.sv
// Shared types for the CHERI tag-memory response block: FSM states and tag granule size.
package ibex_pkg;

   localparam int unsigned TagGranuleBytes = 8;

   typedef enum logic [1:0] {
      TAG_IDLE      = 2'd0,
      TAG_WAIT_RESP = 2'd1,
      TAG_ERR_RESP  = 2'd2,
      TAG_CLEAR     = 2'd3
   } tagmem_state_e;

endpackage

// File: rtl/ibex_cheri_tag_ram.sv
// One-bit-per-granule tag store: one synchronous write port, one asynchronous read port,
// all bits cleared by the asynchronous reset.
module ibex_cheri_tag_ram #(
   parameter int unsigned Depth = 1024,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic             wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic             rdata_o
);

   logic [Depth-1:0] tags_r;

   // tag bit storage with asynchronous clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tags_r <= {Depth{1'b0}};
      end else if (we_i) begin
         tags_r[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = tags_r[raddr_i];

endmodule

// File: rtl/ibex_cheri_tagmem_resp.sv
// Tag-memory shim between the core data port and memory: forwards accesses, tracks one tag
// bit per 8-byte granule. Optional whole-store sweep enabled by IBEX_CHERI_TAGMEM_CLRALL_EN.
module ibex_cheri_tagmem_resp
   import ibex_pkg::*;
#(
   parameter logic [31:0] TagBase  = 32'h0010_0000,
   parameter int unsigned TagDepth = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   input  logic        data_cap_i,
   input  logic        data_wtag_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_rtag_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   input  logic        tag_clr_req_i,
   output logic        tag_clr_busy_o
);

   localparam int unsigned IdxW     = $clog2(TagDepth);
   localparam logic [32:0] TagLimit = {1'b0, TagBase} + 33'(TagDepth * TagGranuleBytes);

   tagmem_state_e   state_r, state_s;
   logic [31:0]     offset_s;
   logic [IdxW-1:0] req_idx_s;
   logic            in_range_s, bad_cap_s, latch_s;
   logic            mem_req_s, data_gnt_s;
   logic [IdxW-1:0] idx_r;
   logic            in_range_r, we_r, cap_r, wtag_r, a2_r;
   logic            tag_we_s, tag_wdata_s, tag_rdata_s;
   logic [IdxW-1:0] tag_waddr_s;
   logic            clr_go_s, clr_last_s;
   logic [IdxW-1:0] clr_idx_s;

   assign offset_s   = data_addr_i - TagBase;
   assign req_idx_s  = IdxW'(offset_s >> 3);
   assign in_range_s = ({1'b0, data_addr_i} >= {1'b0, TagBase}) && ({1'b0, data_addr_i} < TagLimit);
   // A capability half must hit the tag window with a full-word access, else it never reaches memory.
   assign bad_cap_s  = data_cap_i && (!in_range_s || (data_be_i != 4'hF));

   assign mem_addr_o  = data_addr_i;
   assign mem_we_o    = data_we_i;
   assign mem_be_o    = data_be_i;
   assign mem_wdata_o = data_wdata_i;
   assign mem_req_o   = mem_req_s & rst_ni;
   assign data_gnt_o  = data_gnt_s & rst_ni;

`ifdef IBEX_CHERI_TAGMEM_CLRALL_EN
   logic            clr_pend_r;
   logic [IdxW-1:0] clr_idx_r;

   assign clr_go_s       = tag_clr_req_i | clr_pend_r;
   assign clr_idx_s      = clr_idx_r;
   assign clr_last_s     = (clr_idx_r == IdxW'(TagDepth - 1));
   assign tag_clr_busy_o = (state_r == TAG_CLEAR);

   // remember a sweep request that arrives while a transaction is in flight; walk the sweep index
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clr_pend_r <= 1'b0;
         clr_idx_r  <= {IdxW{1'b0}};
      end else begin
         if ((state_r == TAG_IDLE) && clr_go_s) begin
            clr_pend_r <= 1'b0;
         end else if (tag_clr_req_i && (state_r != TAG_CLEAR)) begin
            clr_pend_r <= 1'b1;
         end
         if ((state_r == TAG_CLEAR) && !clr_last_s) begin
            clr_idx_r <= clr_idx_r + IdxW'(1);
         end else begin
            clr_idx_r <= {IdxW{1'b0}};
         end
      end
   end
`else
   logic unused_clr_req_s;

   assign unused_clr_req_s = tag_clr_req_i;
   assign clr_go_s         = 1'b0;
   assign clr_idx_s        = {IdxW{1'b0}};
   assign clr_last_s       = 1'b1;
   assign tag_clr_busy_o   = 1'b0;
`endif

   // next state, core/memory handshake, response and tag-write decode
   always_comb begin
      state_s       = state_r;
      mem_req_s     = 1'b0;
      data_gnt_s    = 1'b0;
      data_rvalid_o = 1'b0;
      data_err_o    = 1'b0;
      data_rtag_o   = 1'b0;
      data_rdata_o  = 32'h0;
      latch_s       = 1'b0;
      tag_we_s      = 1'b0;
      tag_waddr_s   = idx_r;
      tag_wdata_s   = 1'b0;
      case (state_r)
         TAG_IDLE: begin
            if (clr_go_s) begin
               state_s = TAG_CLEAR;
            end else if (data_req_i) begin
               if (bad_cap_s) begin
                  data_gnt_s = 1'b1;
                  state_s    = TAG_ERR_RESP;
               end else begin
                  mem_req_s  = 1'b1;
                  data_gnt_s = mem_gnt_i;
                  if (mem_gnt_i) begin
                     latch_s = 1'b1;
                     state_s = TAG_WAIT_RESP;
                  end else begin
                     state_s = TAG_IDLE;
                  end
               end
            end else begin
               state_s = TAG_IDLE;
            end
         end
         TAG_WAIT_RESP: begin
            if (mem_rvalid_i) begin
               data_rvalid_o = 1'b1;
               data_rdata_o  = mem_rdata_i;
               data_err_o    = mem_err_i;
               data_rtag_o   = !we_r && cap_r && in_range_r && tag_rdata_s;
               state_s       = TAG_IDLE;
               // Only the upper capability half carries the tag; a plain store into the window kills it.
               if (we_r && !mem_err_i) begin
                  if (cap_r) begin
                     tag_we_s    = a2_r;
                     tag_wdata_s = wtag_r;
                  end else begin
                     tag_we_s    = in_range_r;
                     tag_wdata_s = 1'b0;
                  end
               end else begin
                  tag_we_s = 1'b0;
               end
            end else begin
               state_s = TAG_WAIT_RESP;
            end
         end
         TAG_ERR_RESP: begin
            data_rvalid_o = 1'b1;
            data_err_o    = 1'b1;
            state_s       = TAG_IDLE;
         end
         TAG_CLEAR: begin
            tag_we_s    = 1'b1;
            tag_waddr_s = clr_idx_s;
            if (clr_last_s) begin
               state_s = TAG_IDLE;
            end else begin
               state_s = TAG_CLEAR;
            end
         end
         default: begin
            state_s = TAG_IDLE;
         end
      endcase
   end

   // state register and fields captured at grant
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= TAG_IDLE;
         idx_r      <= {IdxW{1'b0}};
         in_range_r <= 1'b0;
         we_r       <= 1'b0;
         cap_r      <= 1'b0;
         wtag_r     <= 1'b0;
         a2_r       <= 1'b0;
      end else begin
         state_r <= state_s;
         if (latch_s) begin
            idx_r      <= req_idx_s;
            in_range_r <= in_range_s;
            we_r       <= data_we_i;
            cap_r      <= data_cap_i;
            wtag_r     <= data_wtag_i;
            a2_r       <= data_addr_i[2];
         end
      end
   end

   ibex_cheri_tag_ram #(
      .Depth (TagDepth)
   ) u_tag_ram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (tag_we_s),
      .waddr_i (tag_waddr_s),
      .wdata_i (tag_wdata_s),
      .raddr_i (idx_r),
      .rdata_o (tag_rdata_s)
   );

endmodule

// File: tb/tb_ibex_cheri_tagmem_resp.sv
// Directed bench for ibex_cheri_tagmem_resp: tag set/kill rules, bad capability accesses,
// store errors, window boundaries, sweep (IBEX_CHERI_TAGMEM_CLRALL_EN) and mid-flight reset.
module tb_ibex_cheri_tagmem_resp;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        data_req_i, data_we_i, data_cap_i, data_wtag_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic [3:0]  data_be_i;
   logic        data_gnt_o, data_rvalid_o, data_rtag_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_rdata_i;
   logic        tag_clr_req_i, tag_clr_busy_o;

   int vectors     = 0;
   int miscompares = 0;
   int busy_cycles;

   always #5 clk_i = ~clk_i;

   ibex_cheri_tagmem_resp #(
      .TagBase  (32'h0010_0000),
      .TagDepth (1024)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .data_req_i     (data_req_i),
      .data_addr_i    (data_addr_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_wdata_i   (data_wdata_i),
      .data_cap_i     (data_cap_i),
      .data_wtag_i    (data_wtag_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .data_rtag_o    (data_rtag_o),
      .data_err_o     (data_err_o),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .mem_err_i      (mem_err_i),
      .tag_clr_req_i  (tag_clr_req_i),
      .tag_clr_busy_o (tag_clr_busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction: request, grant, response fed from rdata, then idle check.
   task automatic access(input string tag, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata, input logic cap,
                         input logic wtag, input logic merr, input logic exp_fwd,
                         input logic [31:0] rdata, input logic exp_rtag, input logic exp_err);
      @(negedge clk_i);
      data_req_i   = 1'b1;
      data_addr_i  = addr;
      data_we_i    = we;
      data_be_i    = be;
      data_wdata_i = wdata;
      data_cap_i   = cap;
      data_wtag_i  = wtag;
      #1;
      chk({tag, "_gnt"}, data_gnt_o, 1'b1);
      chk({tag, "_mreq"}, mem_req_o, exp_fwd);
      if (exp_fwd) chk({tag, "_maddr"}, mem_addr_o, addr);
      @(negedge clk_i);
      data_req_i = 1'b0;
      chk({tag, "_mreq_wait"}, mem_req_o, 1'b0);
      if (exp_fwd) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = rdata;
         mem_err_i    = merr;
      end
      #1;
      chk({tag, "_rvalid"}, data_rvalid_o, 1'b1);
      if (exp_fwd) chk({tag, "_rdata"}, data_rdata_o, rdata);
      chk({tag, "_rtag"}, data_rtag_o, exp_rtag);
      chk({tag, "_err"}, data_err_o, exp_err);
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
      #1;
      chk({tag, "_idle_rvalid"}, data_rvalid_o, 1'b0);
      chk({tag, "_idle_err"}, data_err_o, 1'b0);
   endtask

   initial begin
      rst_ni        = 1'b0;
      data_req_i    = 1'b1;
      data_addr_i   = 32'h0000_2000;
      data_we_i     = 1'b0;
      data_be_i     = 4'hF;
      data_wdata_i  = 32'h0;
      data_cap_i    = 1'b0;
      data_wtag_i   = 1'b0;
      mem_gnt_i     = 1'b1;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = 32'h0;
      mem_err_i     = 1'b0;
      tag_clr_req_i = 1'b0;
      #1;
      chk("rst_mreq", mem_req_o, 1'b0);
      chk("rst_gnt", data_gnt_o, 1'b0);
      chk("rst_rvalid", data_rvalid_o, 1'b0);
      chk("rst_busy", tag_clr_busy_o, 1'b0);
      repeat (2) @(negedge clk_i);
      data_req_i = 1'b0;
      rst_ni     = 1'b1;

      // lower half store keeps tag, upper half store sets it
      access("cst_lo",  32'h0010_0008, 1'b1, 4'hF, 32'hAAAA_5555, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      access("cst_hi",  32'h0010_000C, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      access("cld_lo",  32'h0010_0008, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA_5555, 1'b1, 1'b0);
      access("cld_hi",  32'h0010_000C, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
      access("ld_nocap", 32'h0010_0008, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_5555, 1'b0, 1'b0);
      // plain byte store into the granule kills the tag
      access("bst",     32'h0010_000A, 1'b1, 4'b0100, 32'h00BB_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      access("cld_kill", 32'h0010_000C, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      // rejected capability accesses
      access("cld_oor", 32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      access("cld_be",  32'h0010_0008, 1'b0, 4'h3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      access("cld_end", 32'h0010_2000, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      access("cld_pre", 32'h000F_FFFC, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      // plain access outside the window passes through
      access("ld_oor",  32'h0000_2000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
      // erroring store leaves the tag alone
      access("cst_err", 32'h0010_0014, 1'b1, 4'hF, 32'h5A5A_5A5A, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
      access("cld_err", 32'h0010_0010, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      // last granule of the window
      access("cst_last", 32'h0010_1FFC, 1'b1, 4'hF, 32'h0F0F_0F0F, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      access("cld_last", 32'h0010_1FF8, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_2222, 1'b1, 1'b0);
      access("cst_set1", 32'h0010_000C, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

`ifdef IBEX_CHERI_TAGMEM_CLRALL_EN
      // sweep requested while a load is outstanding, honoured afterwards
      @(negedge clk_i);
      data_req_i  = 1'b1;
      data_addr_i = 32'h0010_0008;
      data_we_i   = 1'b0;
      data_be_i   = 4'hF;
      data_cap_i  = 1'b1;
      @(negedge clk_i);
      data_req_i    = 1'b0;
      tag_clr_req_i = 1'b1;
      mem_rvalid_i  = 1'b1;
      mem_rdata_i   = 32'hAABB_5555;
      #1;
      chk("clr_wait_rvalid", data_rvalid_o, 1'b1);
      chk("clr_wait_rtag", data_rtag_o, 1'b1);
      chk("clr_wait_busy", tag_clr_busy_o, 1'b0);
      @(negedge clk_i);
      tag_clr_req_i = 1'b0;
      mem_rvalid_i  = 1'b0;
      data_req_i    = 1'b1;
      data_addr_i   = 32'h0000_2000;
      data_cap_i    = 1'b0;
      #1;
      chk("clr_pend_gnt", data_gnt_o, 1'b0);
      chk("clr_pend_mreq", mem_req_o, 1'b0);
      busy_cycles = 0;
      for (int i = 0; i < 2100; i++) begin
         @(negedge clk_i);
         #1;
         if (tag_clr_busy_o) begin
            busy_cycles++;
            chk("clr_sweep_gnt", data_gnt_o, 1'b0);
            chk("clr_sweep_mreq", mem_req_o, 1'b0);
         end else begin
            break;
         end
      end
      data_req_i = 1'b0;
      chk("clr_busy_cycles", busy_cycles, 32'd1024);
      access("clr_cld1",    32'h0010_0008, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAABB_5555, 1'b0, 1'b0);
      access("clr_cldlast", 32'h0010_1FF8, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0);
      access("cst_set2",    32'h0010_000C, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
`else
      // sweep request has no effect in this build
      @(negedge clk_i);
      tag_clr_req_i = 1'b1;
      @(negedge clk_i);
      tag_clr_req_i = 1'b0;
      #1;
      chk("noclr_busy", tag_clr_busy_o, 1'b0);
      access("noclr_cld", 32'h0010_1FF8, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_2222, 1'b1, 1'b0);
`endif

      // reset while a response is outstanding
      @(negedge clk_i);
      data_req_i  = 1'b1;
      data_addr_i = 32'h0010_000C;
      data_we_i   = 1'b0;
      data_be_i   = 4'hF;
      data_cap_i  = 1'b1;
      @(negedge clk_i);
      data_req_i = 1'b0;
      rst_ni     = 1'b0;
      #1;
      chk("mrst_rvalid", data_rvalid_o, 1'b0);
      chk("mrst_gnt", data_gnt_o, 1'b0);
      chk("mrst_busy", tag_clr_busy_o, 1'b0);
      @(negedge clk_i);
      rst_ni       = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_BEEF;
      #1;
      chk("mrst_stray_rvalid", data_rvalid_o, 1'b0);
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      access("mrst_cld1",    32'h0010_000C, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      access("mrst_cldlast", 32'h0010_1FF8, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
